// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage hazard and stall controller for a 5-stage MIPS pipeline.
//
// Compares the sources of the instruction in ID against the destinations in flight in EX and MEM.
// It drives the PC / IF-ID write enables, the IF-ID flush, the ID-EX bubble and the ID-stage
// branch-compare forwarding selects.
// The remaining stall length sits in a registered counter, so a multi-cycle stall runs to
// completion without being re-decoded.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   opcode, idRs, idRt          fields of the instruction in ID
//   exDest/exRegWrite/exMemRead       EX-stage destination, write enable, load flag
//   memDest/memRegWrite/memMemRead    MEM-stage destination, write enable, load flag
//   pcSrc, jump                 taken branch / jump resolved in ID
//   pcWrite, ifidWrite          PC and IF/ID load enables (low while stalling)
//   ifidFlush                   clear IF/ID to a nop at the next edge
//   idexBubble                  load zeroed controls into ID/EX at the next edge
//   forwardC, forwardD          select MEMData for the rs / rt branch-compare operand
//   stalled                     registered, high while the stall counter is nonzero
//   stallCount, flushCount      (HAZARD_STATS_EN only) saturating event counters
//
// Optional feature macro: HAZARD_STATS_EN adds stallCount / flushCount.

module id_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic [4:0] exDest,
  input  logic       exRegWrite,
  input  logic       exMemRead,
  input  logic [4:0] memDest,
  input  logic       memRegWrite,
  input  logic       memMemRead,
  input  logic       pcSrc,
  input  logic       jump,
  output logic       pcWrite,
  output logic       ifidWrite,
  output logic       ifidFlush,
  output logic       idexBubble,
  output logic       forwardC,
  output logic       forwardD,
  output logic       stalled
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
`endif
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpSw    = 6'b101011;

  state_e     stateQ, stateD;
  logic [1:0] cntQ, cntD;
  logic       stalledQ;

  logic       isBranch, usesRs, usesRt;
  logic       exHit, memHit;
  logic       exLoadMatch, exAluMatch, memLoadMatch;
  logic [1:0] needN;

  // Source-use decode
  assign isBranch = (opcode == OpBeq) || (opcode == OpBne);
  assign usesRt   = (opcode == OpRType) || isBranch || (opcode == OpSw);
  assign usesRs   = (opcode != OpJ);

  // $zero is never a real dependency
  assign exHit  = exRegWrite && (exDest != 5'd0) &&
                  ((usesRs && (exDest == idRs)) || (usesRt && (exDest == idRt)));
  assign memHit = memRegWrite && (memDest != 5'd0) &&
                  ((usesRs && (memDest == idRs)) || (usesRt && (memDest == idRt)));

  assign exLoadMatch  = exHit && exMemRead;
  assign exAluMatch   = exHit && !exMemRead;
  assign memLoadMatch = memHit && memMemRead;

  // Largest applicable stall length
  always_comb begin
    needN = 2'd0;
    if (isBranch) begin
      if (exLoadMatch) begin
        needN = 2'd2;
      end else if (exAluMatch || memLoadMatch) begin
        needN = 2'd1;
      end
    end else if (exLoadMatch) begin
      needN = 2'd1;
    end
  end

  // Branch-compare forwarding from MEM (ALU results only; loads are covered by stalling)
  assign forwardC = memRegWrite && !memMemRead && (memDest != 5'd0) && (memDest == idRs);
  assign forwardD = memRegWrite && !memMemRead && (memDest != 5'd0) && (memDest == idRt);

  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    unique case (stateQ)
      StRun: begin
        if (needN != 2'd0) begin
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexBubble = 1'b1;
          cntD       = needN - 2'd1;
          stateD     = (needN > 2'd1) ? StStall : StRun;
        end else begin
          ifidFlush = pcSrc | jump;
        end
      end
      StStall: begin
        // Hazards and pcSrc/jump are ignored; the branch re-resolves once back in StRun.
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
        cntD       = cntQ - 2'd1;
        stateD     = (cntQ == 2'd1) ? StRun : StStall;
      end
      default: begin
        stateD = StRun;
        cntD   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= StRun;
      cntQ     <= 2'd0;
      stalledQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      stalledQ <= (cntD != 2'd0);
    end
  end

  assign stalled = stalledQ;

`ifdef HAZARD_STATS_EN
  logic [15:0] stallCountQ, flushCountQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCountQ <= 16'd0;
      flushCountQ <= 16'd0;
    end else begin
      if (!pcWrite && (stallCountQ != 16'hFFFF)) begin
        stallCountQ <= stallCountQ + 16'd1;
      end
      if (ifidFlush && (flushCountQ != 16'hFFFF)) begin
        flushCountQ <= flushCountQ + 16'd1;
      end
    end
  end

  assign stallCount = stallCountQ;
  assign flushCount = flushCountQ;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios followed by random traffic, all
// compared against a behavioural model that tracks "stall cycles still owed".
// Stats checks are built only when HAZARD_STATS_EN is defined.

module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [4:0] idRs, idRt, exDest, memDest;
  logic       exRegWrite, exMemRead, memRegWrite, memMemRead, pcSrc, jump;
  logic       pcWrite, ifidWrite, ifidFlush, idexBubble, forwardC, forwardD, stalled;
`ifdef HAZARD_STATS_EN
  logic [15:0] stallCount, flushCount;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state
  int remaining = 0;
  int mStalls   = 0;
  int mFlushes  = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .idRs        (idRs),
    .idRt        (idRt),
    .exDest      (exDest),
    .exRegWrite  (exRegWrite),
    .exMemRead   (exMemRead),
    .memDest     (memDest),
    .memRegWrite (memRegWrite),
    .memMemRead  (memMemRead),
    .pcSrc       (pcSrc),
    .jump        (jump),
    .pcWrite     (pcWrite),
    .ifidWrite   (ifidWrite),
    .ifidFlush   (ifidFlush),
    .idexBubble  (idexBubble),
    .forwardC    (forwardC),
    .forwardD    (forwardD),
    .stalled     (stalled)
`ifdef HAZARD_STATS_EN
    ,
    .stallCount  (stallCount),
    .flushCount  (flushCount)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register numbers the ID instruction reads, straight from the opcode table.
  function automatic bit reads(input logic [5:0] op, input logic [4:0] r);
    bit br;
    br = (op == 6'd4) || (op == 6'd5);
    if (r == 5'd0) return 1'b0;
    if (op == 6'd2) return 1'b0;
    if (r == idRs) return 1'b1;
    if ((op == 6'd0 || br || op == 6'h2b) && r == idRt) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int requiredStall();
    bit br, exMatch, memMatch;
    int n;
    br       = (opcode == 6'd4) || (opcode == 6'd5);
    exMatch  = exRegWrite && reads(opcode, exDest);
    memMatch = memRegWrite && reads(opcode, memDest);
    n = 0;
    if (br && exMatch && exMemRead) n = (n > 2) ? n : 2;
    if (br && exMatch && !exMemRead) n = (n > 1) ? n : 1;
    if (br && memMatch && memMemRead) n = (n > 1) ? n : 1;
    if (!br && exMatch && exMemRead) n = (n > 1) ? n : 1;
    return n;
  endfunction

  task automatic idle();
    opcode = 6'h08; idRs = 5'd0; idRt = 5'd0;
    exDest = 5'd0; exRegWrite = 1'b0; exMemRead = 1'b0;
    memDest = 5'd0; memRegWrite = 1'b0; memMemRead = 1'b0;
    pcSrc = 1'b0; jump = 1'b0;
  endtask

  // One cycle: inputs are already applied; check at negedge, advance the model past posedge.
  task automatic step(input string tag);
    int  n;
    bit  stall, flush, fc, fd;
    @(negedge clk);
    n     = requiredStall();
    stall = (remaining > 0) || (n > 0);
    flush = !stall && (pcSrc || jump);
    fc    = memRegWrite && !memMemRead && memDest != 5'd0 && memDest == idRs;
    fd    = memRegWrite && !memMemRead && memDest != 5'd0 && memDest == idRt;
    check({tag, ".pcWrite"},    16'(pcWrite),    16'(!stall));
    check({tag, ".ifidWrite"},  16'(ifidWrite),  16'(!stall));
    check({tag, ".idexBubble"}, 16'(idexBubble), 16'(stall));
    check({tag, ".ifidFlush"},  16'(ifidFlush),  16'(flush));
    check({tag, ".forwardC"},   16'(forwardC),   16'(fc));
    check({tag, ".forwardD"},   16'(forwardD),   16'(fd));
    check({tag, ".stalled"},    16'(stalled),    16'(remaining > 0));
    @(posedge clk);
    if (stall && mStalls < 65535) mStalls++;
    if (flush && mFlushes < 65535) mFlushes++;
    if (remaining > 0) remaining--;
    else if (n > 0) remaining = n - 1;
    #1;
  endtask

  task automatic checkStats(input string tag);
`ifdef HAZARD_STATS_EN
    @(negedge clk);
    check({tag, ".stallCount"}, stallCount, 16'(mStalls));
    check({tag, ".flushCount"}, flushCount, 16'(mFlushes));
    @(posedge clk);
    #1;
`else
    if (tag.len() == 0) $display("unnamed stats tag");
`endif
  endtask

  task automatic doReset();
    rst = 1'b0;
    remaining = 0; mStalls = 0; mFlushes = 0;
    #1;
    check("reset.stalled", 16'(stalled), 16'd0);
  endtask

  initial begin
    // Reset with random inputs, then release with idle inputs
    rst = 1'b1;
    opcode = 6'($urandom); idRs = 5'($urandom); idRt = 5'($urandom);
    exDest = 5'($urandom); exRegWrite = 1'($urandom); exMemRead = 1'($urandom);
    memDest = 5'($urandom); memRegWrite = 1'($urandom); memMemRead = 1'($urandom);
    pcSrc = 1'($urandom); jump = 1'($urandom);
    #2;
    doReset();
    repeat (2) @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    step("idle");
    checkStats("resetStats");

    // Load-use: one stall cycle, no stalled pulse
    exMemRead = 1'b1; exRegWrite = 1'b1; exDest = 5'd8; opcode = 6'd0; idRs = 5'd8; idRt = 5'd3;
    step("loadUse");
    idle();
    step("loadUseAfter");

    // Branch after load: two stall cycles, flush suppressed
    exMemRead = 1'b1; exRegWrite = 1'b1; exDest = 5'd9; opcode = 6'd4; idRs = 5'd1; idRt = 5'd9;
    pcSrc = 1'b1;
    step("brLoad1");
    step("brLoad2");
    idle();
    pcSrc = 1'b1; opcode = 6'd4;
    step("brLoadResolve");

    // Branch after ALU, then forward from MEM and take the branch
    idle();
    exRegWrite = 1'b1; exDest = 5'd10; opcode = 6'd4; idRs = 5'd10; idRt = 5'd2; pcSrc = 1'b1;
    step("brAlu");
    exRegWrite = 1'b0; memDest = 5'd10; memRegWrite = 1'b1;
    step("brAluFwd");

    // $zero never matches
    idle();
    exMemRead = 1'b1; exRegWrite = 1'b1; exDest = 5'd0; opcode = 6'd0; idRs = 5'd0;
    step("zeroDest");
    // Jump reads no sources even when IR bits match EX
    idle();
    exMemRead = 1'b1; exRegWrite = 1'b1; exDest = 5'd5; opcode = 6'd2; idRs = 5'd5; idRt = 5'd5;
    jump = 1'b1;
    step("jump");
    // MEM load in front of a branch
    idle();
    memMemRead = 1'b1; memRegWrite = 1'b1; memDest = 5'd7; opcode = 6'd5; idRt = 5'd7;
    step("brMemLoad");
    idle();
    step("brMemLoadAfter");
    checkStats("directedStats");

    // Reset mid-stall aborts it immediately
    exMemRead = 1'b1; exRegWrite = 1'b1; exDest = 5'd9; opcode = 6'd4; idRs = 5'd9;
    step("preAbort");
    idle();
    doReset();
    check("abort.pcWrite", 16'(pcWrite), 16'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("postAbort");

    // Random traffic on a small register window so matches are frequent
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] ops [7];
      ops = '{6'd0, 6'd4, 6'd5, 6'h2b, 6'd2, 6'h08, 6'h23};
      opcode      = ops[$urandom_range(0, 6)];
      idRs        = 5'($urandom_range(0, 3));
      idRt        = 5'($urandom_range(0, 3));
      exDest      = 5'($urandom_range(0, 3));
      exRegWrite  = 1'($urandom);
      exMemRead   = 1'($urandom);
      memDest     = 5'($urandom_range(0, 3));
      memRegWrite = 1'($urandom);
      memMemRead  = 1'($urandom);
      pcSrc       = 1'($urandom);
      jump        = 1'($urandom);
      step("rand");
    end
    checkStats("randStats");

`ifdef HAZARD_STATS_EN
    // 3 stalls and 2 flushes from a clean reset
    @(negedge clk);
    idle();
    doReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      idle();
      exMemRead = 1'b1; exRegWrite = 1'b1; exDest = 5'd4; opcode = 6'd0; idRs = 5'd4;
      step("stat3");
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      jump = 1'b1;
      step("stat2");
    end
    idle();
    step("statIdle");
    checkStats("countStats");
    // Saturation: continuous load-use stalls
    idle();
    exMemRead = 1'b1; exRegWrite = 1'b1; exDest = 5'd4; opcode = 6'd0; idRs = 5'd4;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      if (mStalls < 65535) mStalls++;
    end
    #1;
    idle();
    checkStats("satStats");
    check("sat.value", stallCount, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Hazard and stall controller for the decode stage of the 5-stage MIPS pipeline. It watches the instruction in ID and the destinations in flight in EX and MEM, and drives the pipeline-register controls: PC/IF-ID write enables, IF-ID flush and ID-EX bubble. It also drives the ID-stage branch-compare forwarding selects (forwardC/forwardD). Stall sequencing is held in a registered counter, so a multi-cycle stall runs to completion without being re-decoded.

## Interface
- No parameters.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26] of the instruction in ID.
- idRs  input  5  IR[25:21] in ID.
- idRt  input  5  IR[20:16] in ID.
- exDest  input  5  destination register of the instruction in EX.
- exRegWrite  input  1  EX instruction writes the register file.
- exMemRead  input  1  EX instruction is a load.
- memDest  input  5  destination register of the instruction in MEM.
- memRegWrite  input  1  MEM instruction writes the register file.
- memMemRead  input  1  MEM instruction is a load.
- pcSrc  input  1  branch taken, resolved in ID.
- jump  input  1  jump decoded in ID.
- pcWrite  output  1  PC load enable.
- ifidWrite  output  1  IF/ID load enable.
- ifidFlush  output  1  clear IF/ID to a nop at the next edge.
- idexBubble  output  1  load zeroed controls into ID/EX at the next edge.
- forwardC  output  1  select MEMData for the rs compare operand.
- forwardD  output  1  select MEMData for the rt compare operand.
- stalled  output  1  registered; 1 while the counter is nonzero.

## Operation
- Source use, decoded from opcode:
  - R-type (000000), beq (000100), bne (000101) and sw (101011) use both rs and rt.
  - j (000010) uses neither.
  - All other opcodes use rs only.
- isBranch is opcode 000100 or 000101.
- A match needs a write-enable, a destination of 5'd0 never matches, and the register must be a used source.
- Required stall count N, evaluated only in state RUN, largest rule wins:
  - Branch plus EX load match: N=2.
  - Branch plus EX ALU match (exRegWrite and not exMemRead): N=1.
  - Branch plus MEM load match: N=1.
  - Non-branch plus EX load match: N=1.
  - Otherwise N=0.
- States:
  - RUN (cnt=0): if N>0, assert the stall outputs (pcWrite=0, ifidWrite=0, idexBubble=1) and load cnt=N-1. The state is STALL if N-1>0, otherwise it stays RUN.
  - STALL (cnt>0): assert the stall outputs and decrement cnt. Hazard detection and pcSrc/jump are ignored. The state returns to RUN when cnt reaches 0.
- Flush: in RUN with N=0, ifidFlush = pcSrc | jump. ifidFlush is never asserted in a stall cycle. A branch that needs a stall is re-resolved in the first RUN cycle after the stall.
- forwardC = memRegWrite & ~memMemRead & (memDest!=0) & (memDest==idRs). forwardD is the same with idRt. Both are combinational and evaluated in every state.
- Simultaneous events: the stall takes priority over the flush, and the flush never gates pcWrite.

## Timing
- Reset (rst=0, asynchronous): cnt=0, state RUN, stalled=0.
- With idle inputs, outputs are pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0, forwardC=0, forwardD=0.
- Stall outputs in the detection cycle are combinational, so there is zero latency. Cycles after the first are driven from registered cnt.
- A stall with N=2 holds PC for exactly 2 edges. A stall with N=1 holds PC for exactly 1 edge.
- stalled rises one cycle after detection, and only when N=2.
- Reset asserted mid-stall aborts the stall immediately: state returns to RUN and cnt to 0.

## Configuration
- HAZARD_STATS_EN defined:
  - Adds output stallCount[15:0], which counts cycles with pcWrite=0.
  - Adds output flushCount[15:0], which counts cycles with ifidFlush=1.
  - Both are saturating at 16'hFFFF and asynchronously reset to 0.
- HAZARD_STATS_EN undefined: the stall/flush count outputs and their counters are absent, and all other behaviour is identical.

## Test plan
- Reset check: apply rst=0 with random inputs, then release -> pcWrite=1, ifidWrite=1, stalled=0 and cnt=0 on the first cycle after release.
- Load-use: exMemRead=1, exRegWrite=1, exDest=8; ID add with idRs=8 -> one cycle of pcWrite=0/idexBubble=1, then pcWrite=1 with no stalled pulse.
- Branch after load: exMemRead=1, exDest=9; ID beq with idRt=9 -> pcWrite=0 for 2 cycles, stalled=1 in the 2nd cycle, and ifidFlush=0 even with pcSrc=1.
- Branch after ALU, then forward: exRegWrite=1, exDest=10; beq with idRs=10 -> 1 stall. Next cycle memDest=10, memRegWrite=1 -> forwardC=1, and pcSrc=1 gives ifidFlush=1.
- $zero and unused sources: exDest=0 with a load and idRs=0 -> no stall; j with exDest matching IR bits -> no stall, ifidFlush=1.
- Stats (HAZARD_STATS_EN): 3 stalls and 2 flushes -> stallCount=3, flushCount=2; force 70000 stall cycles -> stallCount=16'hFFFF.
